mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide sequencer for the CPU datapath; owns the HI/LO architectural registers.
- Accepts one operation per start pulse and computes the result at acceptance.
- Holds busy for a fixed latency so the hazard unit stalls dependent MF*/MD instructions, then commits the result to HI/LO.

---
 rtl/mdu_ctrl.sv | 143 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO registers; the result is computed at
// acceptance and committed after a fixed busy latency. Optional build macro: MDU_DIVZERO_KEEP_EN.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] hi_t_r;
  logic [31:0] lo_t_r;

  logic [63:0] smul_s;
  logic [63:0] umul_s;
  logic [31:0] abs_a_s;
  logic [31:0] abs_b_s;
  logic [31:0] sdiv_b_s;
  logic [31:0] udiv_b_s;
  logic [31:0] mag_q_s;
  logic [31:0] mag_r_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;
  logic [31:0] res_hi_s;
  logic [31:0] res_lo_s;

  // Result datapath: products and quotients for the op being accepted this cycle.
  always_comb begin
    smul_s   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    umul_s   = {32'h0000_0000, rs} * {32'h0000_0000, rt};
    abs_a_s  = rs[31] ? (32'h0000_0000 - rs) : rs;
    abs_b_s  = rt[31] ? (32'h0000_0000 - rt) : rt;
    // Divisors are forced non-zero so the dividers never see a zero; the zero case is muxed below.
    sdiv_b_s = (rt == 32'h0000_0000) ? 32'h0000_0001 : abs_b_s;
    udiv_b_s = (rt == 32'h0000_0000) ? 32'h0000_0001 : rt;
    mag_q_s  = abs_a_s / sdiv_b_s;
    mag_r_s  = abs_a_s % sdiv_b_s;
    uq_s     = rs / udiv_b_s;
    ur_s     = rs % udiv_b_s;
    res_hi_s = 32'h0000_0000;
    res_lo_s = 32'h0000_0000;
    if ((op[1] == 1'b1) && (rt == 32'h0000_0000)) begin
`ifdef MDU_DIVZERO_KEEP_EN
      res_hi_s = hi;
      res_lo_s = lo;
`else
      res_hi_s = rs;
      res_lo_s = 32'hFFFF_FFFF;
`endif
    end else begin
      case (op[1:0])
        2'd0: begin
          res_hi_s = smul_s[63:32];
          res_lo_s = smul_s[31:0];
        end
        2'd1: begin
          res_hi_s = umul_s[63:32];
          res_lo_s = umul_s[31:0];
        end
        2'd2: begin
          res_lo_s = (rs[31] ^ rt[31]) ? (32'h0000_0000 - mag_q_s) : mag_q_s;
          res_hi_s = rs[31] ? (32'h0000_0000 - mag_r_s) : mag_r_s;
        end
        2'd3: begin
          res_hi_s = ur_s;
          res_lo_s = uq_s;
        end
        default: begin
          res_hi_s = 32'h0000_0000;
          res_lo_s = 32'h0000_0000;
        end
      endcase
    end
  end

  // Sequencer: accept, count down the fixed latency, commit HI/LO with a one-cycle done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      hi_t_r  <= 32'h0000_0000;
      lo_t_r  <= 32'h0000_0000;
      hi      <= 32'h0000_0000;
      lo      <= 32'h0000_0000;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            case (op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                hi_t_r  <= res_hi_s;
                lo_t_r  <= res_lo_s;
                cnt_r   <= op[1] ? DIV_LOAD : MULT_LOAD;
                state_r <= RUN;
                busy    <= 1'b1;
              end
              3'd4: hi <= rs;
              3'd5: lo <= rs;
              default: state_r <= IDLE;
            endcase
          end
        end
        RUN: begin
          // Any start seen here is dropped; the hazard unit should never issue one.
          if (cnt_r == 4'd1) begin
            hi      <= hi_t_r;
            lo      <= lo_t_r;
            done    <= 1'b1;
            busy    <= 1'b0;
            cnt_r   <= 4'd0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected commits and busy lengths,
// a negedge monitor pops and compares whenever done or a busy window ends.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] exp_q[$];
  int          len_q[$];
  int          busy_cnt = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs(rs), .rt(rt),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: commits against the result queue, busy windows against the length queue.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("commit_hi", hi, e[63:32]);
        check("commit_lo", lo, e[31:0]);
      end
    end
    if (reset) begin
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end else if (busy_cnt > 0) begin
      if (len_q.size() == 0) check("spurious_busy", 32'(busy_cnt), 32'd0);
      else check("busy_len", 32'(busy_cnt), 32'(len_q.pop_front()));
      busy_cnt = 0;
    end
  end

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int n);
    exp_q.push_back({eh, el});
    len_q.push_back(n);
    start_op(o, a, b);
    @(negedge clk);
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    check({name, "_hold_hi"}, hi, m_hi);
    check({name, "_hold_lo"}, lo, m_lo);
    wait_done(name);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; rs = 32'h0; rt = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    run_op("mult",   3'd0, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op("multu",  3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 5);
    run_op("mult_nn", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0, 32'hC, 5);
    run_op("multu_big", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 5);
    run_op("div",    3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op("divu",   3'd3, 32'h7, 32'h2, 32'h1, 32'h3, 10);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);

    // MTHI then MTLO on back-to-back cycles
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; rs = 32'h1234_5678;
    @(posedge clk); #1;
    op = 3'd5; rs = 32'hCAFE_BABE;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("mthi", hi, 32'h1234_5678);
    check("mtlo", lo, 32'hCAFE_BABE);
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_done", {31'd0, done}, 32'd0);
    m_hi = 32'h1234_5678; m_lo = 32'hCAFE_BABE;

    // reserved op from IDLE does nothing
    start_op(3'd6, 32'hDEAD_BEEF, 32'h1);
    start_op(3'd7, 32'hDEAD_BEEF, 32'h1);
    @(negedge clk);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", hi, m_hi);
    check("rsvd_lo", lo, m_lo);

    // starts issued while a DIV is in flight are dropped
    exp_q.push_back({32'h2, 32'hE});
    len_q.push_back(10);
    start_op(3'd2, 32'd100, 32'd7);
    start_op(3'd5, 32'hDEAD_0000, 32'h0);
    start_op(3'd0, 32'h7, 32'h7);
    @(negedge clk);
    check("inflight_hi", hi, m_hi);
    check("inflight_lo", lo, m_lo);
    wait_done("inflight");
    m_hi = 32'h2; m_lo = 32'hE;

    // reset in the fourth busy cycle aborts without commit
    start_op(3'd2, 32'd9, 32'd2);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    m_hi = 32'h0; m_lo = 32'h0;

    // divide by zero with hi=lo=0x11 beforehand
    start_op(3'd4, 32'h11, 32'h0);
    start_op(3'd5, 32'h11, 32'h0);
    m_hi = 32'h11; m_lo = 32'h11;
`ifdef MDU_DIVZERO_KEEP_EN
    run_op("divzero", 3'd2, 32'h55, 32'h0, 32'h11, 32'h11, 10);
`else
    run_op("divzero", 3'd2, 32'h55, 32'h0, 32'h55, 32'hFFFF_FFFF, 10);
`endif

    repeat (4) @(negedge clk);
    check("pending_commits", 32'(exp_q.size()), 32'd0);
    check("pending_busy", 32'(len_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
